// File: rtl/sokoban_key_pkg.sv
// Key codes and command encoding shared by the keyboard decoder and the command encoder.
// Definitions only: no latency, no flow control.
package sokoban_key_pkg;

   localparam logic [7:0] ASCII_A_LO      = 8'h61;
   localparam logic [7:0] ASCII_A_UP      = 8'h41;
   localparam logic [7:0] ASCII_W_LO      = 8'h77;
   localparam logic [7:0] ASCII_W_UP      = 8'h57;
   localparam logic [7:0] ASCII_S_LO      = 8'h73;
   localparam logic [7:0] ASCII_S_UP      = 8'h53;
   localparam logic [7:0] ASCII_D_LO      = 8'h64;
   localparam logic [7:0] ASCII_D_UP      = 8'h44;
   localparam logic [7:0] ASCII_M_LO      = 8'h6D;
   localparam logic [7:0] ASCII_M_UP      = 8'h4D;
   localparam logic [7:0] ASCII_ENTER     = 8'h0D;
   localparam logic [7:0] ASCII_ESC       = 8'h1B;
   localparam logic [7:0] ASCII_BACKSPACE = 8'h08;

   // Code value doubles as the arbitration priority (7 wins).
   typedef enum logic [2:0] {
      CMD_M         = 3'd0,
      CMD_ENTER     = 3'd1,
      CMD_BACKSPACE = 3'd2,
      CMD_ESC       = 3'd3,
      CMD_A         = 3'd4,
      CMD_W         = 3'd5,
      CMD_S         = 3'd6,
      CMD_D         = 3'd7
   } cmd_code_t;

   typedef struct packed {
      logic [7:0] ascii;
      logic       released;
   } key_event_t;

   function automatic logic [7:0] cmd_to_ascii(input cmd_code_t code);
      logic [7:0] ascii;
      case (code)
         CMD_D:         ascii = ASCII_D_LO;
         CMD_S:         ascii = ASCII_S_LO;
         CMD_W:         ascii = ASCII_W_LO;
         CMD_A:         ascii = ASCII_A_LO;
         CMD_ESC:       ascii = ASCII_ESC;
         CMD_BACKSPACE: ascii = ASCII_BACKSPACE;
         CMD_ENTER:     ascii = ASCII_ENTER;
         default:       ascii = ASCII_M_LO;
      endcase
      return ascii;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with combinational head read; one-cycle write-to-visible latency.
// Push while full is refused unless a pop happens in the same cycle; pop while empty is ignored.
module cmd_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_dat,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_pop_dat,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_pop_dat = r_mem[r_rd_ptr];

   assign w_pop_ok  = i_pop && !o_empty;
   // A same-cycle pop frees the slot the push needs.
   assign w_push_ok = i_push && (!o_full || w_pop_ok);

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_push_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/key_command_encoder.sv
// Replays command pulses as ASCII press/release events; idle pulse-to-data_ready latency is 2 cycles.
// Events hold stable until i_read; commands queue in cmd_fifo and are dropped (sticky overflow) when it is full.
module key_command_encoder
   import sokoban_key_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int GAP_CYCLES   = 2,
   parameter bit EMIT_RELEASE = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_d_right,
   input  logic       i_s_down,
   input  logic       i_w_up,
   input  logic       i_a_left,
   input  logic       i_esc_retry,
   input  logic       i_backspace_retract,
   input  logic       i_enter_next,
   input  logic       i_m_switch,
   input  logic       i_read,
   output logic [7:0] o_ascii,
   output logic       o_released,
   output logic       o_data_ready,
   output logic       o_busy,
   output logic       o_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_PRESS   = 3'd1;
   localparam logic [2:0] S_PGAP    = 3'd2;
   localparam logic [2:0] S_RELEASE = 3'd3;
   localparam logic [2:0] S_RGAP    = 3'd4;

   logic [7:0]    w_cmd_vec;
   cmd_code_t     w_code;
   logic          w_push;
   logic          w_multi;
   logic          w_pop;
   logic          w_push_ok;
   logic [2:0]    w_head;
   logic          w_full;
   logic          w_empty;
   logic [AW:0]   w_count;
   logic [AW:0]   w_count_nxt;
   logic          w_xfer;

   logic [2:0]    r_state;
   logic [GW-1:0] r_gap;
   key_event_t    r_evt;
   logic          r_data_ready;
   logic          r_busy;
   logic          r_overflow;

   logic [2:0]    w_state_nxt;
   logic [GW-1:0] w_gap_nxt;
   key_event_t    w_evt_nxt;
   logic          w_dr_nxt;

   assign w_cmd_vec = {i_d_right, i_s_down, i_w_up, i_a_left,
                       i_esc_retry, i_backspace_retract, i_enter_next, i_m_switch};

   // Ascending scan: the last set bit seen is the highest priority.
   always_comb begin
      w_code = CMD_M;
      for (int i = 0; i < 8; i++) begin
         if (w_cmd_vec[i]) begin
            w_code = cmd_code_t'(i[2:0]);
         end
      end
   end

   assign w_push  = |w_cmd_vec;
   assign w_multi = (w_cmd_vec & (w_cmd_vec - 8'd1)) != 8'd0;

   cmd_fifo #(
      .WIDTH (3),
      .DEPTH (DEPTH)
   ) u_cmd_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_push     (w_push),
      .i_push_dat (w_code),
      .i_pop      (w_pop),
      .o_pop_dat  (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (w_count)
   );

   assign w_push_ok   = w_push && (!w_full || w_pop);
   assign w_count_nxt = w_count + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop};
   assign w_xfer      = r_data_ready && i_read;

   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = r_gap;
      w_evt_nxt   = r_evt;
      w_dr_nxt    = r_data_ready;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop              = 1'b1;
               w_evt_nxt.ascii    = cmd_to_ascii(cmd_code_t'(w_head));
               w_evt_nxt.released = 1'b0;
               w_dr_nxt           = 1'b1;
               w_state_nxt        = S_PRESS;
            end
         end
         S_PRESS: begin
            if (w_xfer) begin
               w_dr_nxt = 1'b0;
               if (GAP_CYCLES > 0) begin
                  w_state_nxt = S_PGAP;
                  w_gap_nxt   = GAP_LOAD;
               end else if (EMIT_RELEASE) begin
                  w_state_nxt        = S_RELEASE;
                  w_evt_nxt.released = 1'b1;
                  w_dr_nxt           = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_PGAP: begin
            if (r_gap <= GW'(1)) begin
               if (EMIT_RELEASE) begin
                  w_state_nxt        = S_RELEASE;
                  w_evt_nxt.released = 1'b1;
                  w_dr_nxt           = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_gap_nxt = r_gap - 1'b1;
            end
         end
         S_RELEASE: begin
            if (w_xfer) begin
               w_dr_nxt = 1'b0;
               if (GAP_CYCLES > 0) begin
                  w_state_nxt = S_RGAP;
                  w_gap_nxt   = GAP_LOAD;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_RGAP: begin
            if (r_gap <= GW'(1)) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_gap_nxt = r_gap - 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_dr_nxt    = 1'b0;
         end
      endcase
   end

   // busy is registered from next-cycle values so it drops the same cycle the FSM lands in IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_gap        <= '0;
         r_evt        <= '0;
         r_data_ready <= 1'b0;
         r_busy       <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_gap        <= w_gap_nxt;
         r_evt        <= w_evt_nxt;
         r_data_ready <= w_dr_nxt;
         r_busy       <= (w_count_nxt != '0) || (w_state_nxt != S_IDLE);
         r_overflow   <= r_overflow | w_multi | (w_push && !w_push_ok);
      end
   end

   assign o_ascii      = r_evt.ascii;
   assign o_released   = r_evt.released;
   assign o_data_ready = r_data_ready;
   assign o_busy       = r_busy;
   assign o_overflow   = r_overflow;

endmodule
